// File: rtl/e203_subsys_sram_banked.sv
// e203_subsys_sram_banked: ICB slave for the on-chip SRAM window.
// Word-interleaves accesses over NBANK single-port banks, range-checks each
// command, buffers up to RSP_DP in-order responses, and can zero-fill the
// banks after reset before it accepts traffic.
module e203_subsys_sram_banked #(
   parameter int unsigned    AW        = 32,
   parameter int unsigned    DW        = 32,
   parameter logic [AW-1:0]  BASE_ADDR = 'h4000_0000,
   parameter int unsigned    RANGE_LSB = 21,
   parameter int unsigned    NBANK     = 4,
   parameter int unsigned    RSP_DP    = 2,
   parameter int unsigned    INIT_ZERO = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_icb_cmd_valid,
   output logic              i_icb_cmd_ready,
   input  logic [AW-1:0]     i_icb_cmd_addr,
   input  logic              i_icb_cmd_read,
   input  logic [DW-1:0]     i_icb_cmd_wdata,
   input  logic [DW/8-1:0]   i_icb_cmd_wmask,
   output logic              i_icb_rsp_valid,
   input  logic              i_icb_rsp_ready,
   output logic              i_icb_rsp_err,
   output logic [DW-1:0]     i_icb_rsp_rdata,
   output logic              init_done,
   output logic [NBANK-1:0]  bank_act
);

   localparam int unsigned BL   = DW / 8;
   localparam int unsigned WW   = RANGE_LSB - 2;
   localparam int unsigned NBL  = $clog2(NBANK);
   localparam int unsigned BKW  = (NBL > 0) ? NBL : 1;
   localparam int unsigned RW   = (WW > NBL) ? (WW - NBL) : 1;
   localparam int unsigned ROWS = (2 ** WW) / NBANK;
   localparam int unsigned PW   = (RSP_DP > 1) ? $clog2(RSP_DP) : 1;
   localparam int unsigned CW   = $clog2(RSP_DP + 1);

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic          err;
      logic [DW-1:0] rdata;
   } rsp_t;

   // control state
   state_t          r_state;
   state_t          w_state_nxt;
   logic [RW-1:0]   r_init_row;
   logic [RW-1:0]   w_init_row_nxt;
   logic [CW-1:0]   r_credit;
   logic [CW-1:0]   w_credit_nxt;
   logic            r_cmd_ready;
   logic            r_init_done;
   logic            w_cmd_hs;
   logic            w_rsp_hs;

   // address decode
   logic [AW-1:0]   w_off;
   logic            w_err;
   logic [WW-1:0]   w_word;
   logic [BKW-1:0]  w_bank;
   logic [RW-1:0]   w_row;
   logic            w_unused_addr_lsb;

   // bank port
   logic [NBANK-1:0] w_ram_en;
   logic             w_ram_we;
   logic [RW-1:0]    w_ram_row;
   logic [DW-1:0]    w_ram_wdata;
   logic [BL-1:0]    w_ram_wmask;
   logic [DW-1:0]    r_mem  [NBANK][ROWS];
   logic [DW-1:0]    r_dout [NBANK];

   // stage 1
   logic            r_s1_valid;
   logic            r_s1_err;
   logic            r_s1_rd;
   logic [BKW-1:0]  r_s1_bank;
   rsp_t            w_s1_rsp;

   // response FIFO with registered head
   rsp_t            r_fq [RSP_DP];
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [PW-1:0]   w_wptr_nxt;
   logic [PW-1:0]   w_rptr_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   rsp_t            w_head;
   logic            r_rsp_valid;
   logic            r_rsp_err;
   logic [DW-1:0]   r_rsp_rdata;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DP - 1)) ? '0 : p + PW'(1);
   endfunction

   // Window-relative decode into error flag, bank and row
   always_comb begin
      w_off             = i_icb_cmd_addr - BASE_ADDR;
      w_err             = |w_off[AW-1:RANGE_LSB];
      w_word            = w_off[RANGE_LSB-1:2];
      w_bank            = BKW'(w_word % WW'(NBANK));
      w_row             = RW'(w_word / WW'(NBANK));
      w_unused_addr_lsb = ^w_off[1:0];
   end

   // FSM next state and bank port steering
   always_comb begin
      w_state_nxt    = r_state;
      w_init_row_nxt = r_init_row;
      w_cmd_hs       = 1'b0;
      w_ram_en       = '0;
      w_ram_we       = 1'b0;
      w_ram_row      = w_row;
      w_ram_wdata    = i_icb_cmd_wdata;
      w_ram_wmask    = i_icb_cmd_wmask;
      if (!rst_n) begin
         w_state_nxt    = (INIT_ZERO != 0) ? S_INIT : S_RUN;
         w_init_row_nxt = '0;
      end else begin
         unique case (r_state)
            S_INIT: begin
               w_ram_en    = '1;
               w_ram_we    = 1'b1;
               w_ram_row   = r_init_row;
               w_ram_wdata = '0;
               w_ram_wmask = '1;
               if (r_init_row == RW'(ROWS - 1)) begin
                  w_state_nxt    = S_RUN;
                  w_init_row_nxt = '0;
               end else begin
                  w_init_row_nxt = r_init_row + RW'(1);
               end
            end
            S_RUN: begin
               w_cmd_hs = i_icb_cmd_valid & r_cmd_ready;
               if (w_cmd_hs && !w_err) begin
                  w_ram_en[w_bank] = 1'b1;
                  w_ram_we         = ~i_icb_cmd_read;
               end
            end
            default: w_state_nxt = S_RUN;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= (INIT_ZERO != 0) ? S_INIT : S_RUN;
         r_init_row <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_row <= w_init_row_nxt;
      end
   end

   // Outstanding-response credit; both handshakes in one cycle cancel
   always_comb begin
      w_rsp_hs     = r_rsp_valid & i_icb_rsp_ready;
      w_credit_nxt = r_credit;
      if (w_cmd_hs && !w_rsp_hs) begin
         w_credit_nxt = r_credit + CW'(1);
      end else if (!w_cmd_hs && w_rsp_hs) begin
         w_credit_nxt = r_credit - CW'(1);
      end
   end

   // Credit, command-ready and init-done registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_credit    <= '0;
         r_cmd_ready <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         r_credit    <= w_credit_nxt;
         r_cmd_ready <= (w_state_nxt == S_RUN) && (w_credit_nxt < CW'(RSP_DP));
         r_init_done <= (w_state_nxt == S_RUN);
      end
   end

   // Bank arrays: byte-masked write or registered read per enabled bank
   always_ff @(posedge clk) begin
      for (int b = 0; b < NBANK; b++) begin
         if (w_ram_en[b]) begin
            if (w_ram_we) begin
               for (int k = 0; k < BL; k++) begin
                  if (w_ram_wmask[k]) begin
                     r_mem[b][w_ram_row][k*8 +: 8] <= w_ram_wdata[k*8 +: 8];
                  end
               end
            end else begin
               r_dout[b] <= r_mem[b][w_ram_row];
            end
         end
      end
   end

   // Stage 1: remember what each accepted command needs from its bank
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_err   <= 1'b0;
         r_s1_rd    <= 1'b0;
         r_s1_bank  <= '0;
      end else begin
         r_s1_valid <= w_cmd_hs;
         r_s1_err   <= w_cmd_hs & w_err;
         r_s1_rd    <= w_cmd_hs & ~w_err & i_icb_cmd_read;
         r_s1_bank  <= w_bank;
      end
   end

   // FIFO next pointers and the entry that becomes head next cycle
   always_comb begin
      w_s1_rsp.err   = r_s1_err;
      w_s1_rsp.rdata = r_s1_rd ? r_dout[r_s1_bank] : '0;
      w_cnt_nxt      = r_cnt + CW'(r_s1_valid) - CW'(w_rsp_hs);
      w_wptr_nxt     = r_s1_valid ? ptr_inc(r_wptr) : r_wptr;
      w_rptr_nxt     = w_rsp_hs ? ptr_inc(r_rptr) : r_rptr;
      if (r_s1_valid && (r_wptr == w_rptr_nxt)) begin
         w_head = w_s1_rsp;
      end else begin
         w_head = r_fq[w_rptr_nxt];
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (r_s1_valid) begin
         r_fq[r_wptr] <= w_s1_rsp;
      end
   end

   // FIFO pointers, occupancy and registered response outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_wptr      <= w_wptr_nxt;
         r_rptr      <= w_rptr_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rsp_valid <= (w_cnt_nxt != '0);
         r_rsp_err   <= (w_cnt_nxt != '0) & w_head.err;
         r_rsp_rdata <= (w_cnt_nxt != '0) ? w_head.rdata : '0;
      end
   end

   assign i_icb_cmd_ready = r_cmd_ready;
   assign i_icb_rsp_valid = r_rsp_valid;
   assign i_icb_rsp_err   = r_rsp_err;
   assign i_icb_rsp_rdata = r_rsp_rdata;
   assign init_done       = r_init_done;
   assign bank_act        = w_ram_en;

endmodule
